pc_sequencer: RTL and testbench

//  Multi-phase controller for the 8-bit MIPS demo datapath: owns the program counter and steps each

---
 rtl/pc_sequencer_pkg.sv | 21 ++
 rtl/pc_sequencer_pc_next_sel.sv | 18 +
 rtl/pc_sequencer.sv | 97 +++++++++
 tb/tb_pc_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the multi-phase PC sequencer of the 8-bit MIPS demo datapath.
package pc_sequencer_pkg;

  localparam int unsigned STATE_W          = 3;
  localparam int unsigned RESET_PC_DEFAULT = 0;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALTED    = 3'd5
  } state_e;

  // Phases in which an instruction is in flight and halt_req is honoured.
  function automatic logic in_flight(input state_e s);
    return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXECUTE) || (s == ST_WRITEBACK);
  endfunction

endpackage

// File: rtl/pc_sequencer_pc_next_sel.sv
// Next-PC mux: jump beats taken branch beats sequential increment (which wraps silently).
module pc_next_sel #(
  parameter int unsigned PC_WIDTH = 8
) (
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic                jump_i,
  input  logic                branch_i,
  input  logic                acc_zero_i,
  input  logic [PC_WIDTH-1:0] target_i,
  output logic [PC_WIDTH-1:0] next_pc_o
);

  always_comb begin
    if (jump_i || (branch_i && acc_zero_i)) next_pc_o = target_i;
    else                                    next_pc_o = pc_i + PC_WIDTH'(1);
  end

endmodule

// File: rtl/pc_sequencer.sv
// FETCH/DECODE/EXECUTE/WRITEBACK sequencer: owns pc, gates write strobes to WRITEBACK, counts retirements.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = 8,
  parameter int unsigned RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 halt_req,
  input  logic                 jump,
  input  logic                 branch,
  input  logic                 acc_zero,
  input  logic [PC_WIDTH-1:0]  target,
  input  logic                 rf_ren_wen,
  input  logic                 mem_ren_wen,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 fetch_en,
  output logic                 exec_en,
  output logic                 rf_wen_g,
  output logic                 mem_wen_g,
  output logic                 halted,
  output logic [STATE_W-1:0]   state,
  output logic [CNT_WIDTH-1:0] retired
);

  state_e                 state_q, state_d;
  logic                   halt_pend_q, halt_pend_d;
  logic [PC_WIDTH-1:0]    pc_q, next_pc_q, sel_pc;
  logic [CNT_WIDTH-1:0]   retired_q;
  logic                   fetch_en_q, exec_en_q, wb_q, halted_q;

  pc_next_sel #(.PC_WIDTH(PC_WIDTH)) u_next_sel (
    .pc_i       (pc_q),
    .jump_i     (jump),
    .branch_i   (branch),
    .acc_zero_i (acc_zero),
    .target_i   (target),
    .next_pc_o  (sel_pc)
  );

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    halt_pend_d = halt_pend_q;
    unique case (state_q)
      ST_IDLE:      if (run) state_d = ST_FETCH;
      ST_FETCH:     state_d = ST_DECODE;
      ST_DECODE:    state_d = ST_EXECUTE;
      ST_EXECUTE:   state_d = ST_WRITEBACK;
      ST_WRITEBACK: state_d = (halt_pend_q || halt_req) ? ST_HALTED : ST_FETCH;
      ST_HALTED:    if (run) state_d = ST_FETCH;
      default:      state_d = ST_IDLE;
    endcase
    if (in_flight(state_q) && halt_req) halt_pend_d = 1'b1;
    if (state_d == ST_HALTED)           halt_pend_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and wins in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      halt_pend_q <= 1'b0;
      pc_q        <= PC_WIDTH'(RESET_PC);
      next_pc_q   <= PC_WIDTH'(RESET_PC);
      retired_q   <= '0;
      fetch_en_q  <= 1'b0;
      exec_en_q   <= 1'b0;
      wb_q        <= 1'b0;
      halted_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      halt_pend_q <= halt_pend_d;
      if (state_q == ST_EXECUTE) next_pc_q <= sel_pc;
      if (state_q == ST_WRITEBACK) begin
        pc_q      <= next_pc_q;
        retired_q <= retired_q + CNT_WIDTH'(1);
      end
      fetch_en_q  <= (state_d == ST_FETCH);
      exec_en_q   <= (state_d == ST_EXECUTE);
      wb_q        <= (state_d == ST_WRITEBACK);
      halted_q    <= (state_d == ST_IDLE) || (state_d == ST_HALTED);
    end
  end

  assign pc        = pc_q;
  assign state     = state_q;
  assign retired   = retired_q;
  assign fetch_en  = fetch_en_q;
  assign exec_en   = exec_en_q;
  assign halted    = halted_q;
  assign rf_wen_g  = rf_ren_wen  & wb_q;
  assign mem_wen_g = mem_ren_wen & wb_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised bench: an instruction-level model predicts pc, retire count and per-phase outputs.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, halt_req, jump, branch, acc_zero, rf_ren_wen, mem_ren_wen;
  logic [7:0]  target;
  logic [7:0]  pc, pc_fe;
  logic        fetch_en, exec_en, rf_wen_g, mem_wen_g, halted;
  logic        fetch_en_fe, exec_en_fe, rf_wen_g_fe, mem_wen_g_fe, halted_fe;
  logic [2:0]  state, state_fe;
  logic [15:0] retired, retired_fe;

  int errors = 0;
  int checks = 0;

  logic [7:0]  model_pc, model_pc_fe;
  logic [15:0] model_retired;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_WIDTH(8), .RESET_PC(0), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .run(run), .halt_req(halt_req), .jump(jump), .branch(branch),
    .acc_zero(acc_zero), .target(target), .rf_ren_wen(rf_ren_wen), .mem_ren_wen(mem_ren_wen),
    .pc(pc), .fetch_en(fetch_en), .exec_en(exec_en), .rf_wen_g(rf_wen_g), .mem_wen_g(mem_wen_g),
    .halted(halted), .state(state), .retired(retired)
  );

  // Second instance shares all inputs; it only differs in its reset pc, exercising the wrap.
  pc_sequencer #(.PC_WIDTH(8), .RESET_PC(8'hFE), .CNT_WIDTH(16)) u_dut_fe (
    .clk(clk), .reset(reset), .run(run), .halt_req(halt_req), .jump(jump), .branch(branch),
    .acc_zero(acc_zero), .target(target), .rf_ren_wen(rf_ren_wen), .mem_ren_wen(mem_ren_wen),
    .pc(pc_fe), .fetch_en(fetch_en_fe), .exec_en(exec_en_fe), .rf_wen_g(rf_wen_g_fe),
    .mem_wen_g(mem_wen_g_fe), .halted(halted_fe), .state(state_fe), .retired(retired_fe)
  );

  function automatic logic [7:0] ref_next(input logic [7:0] cur, input logic j, b, z,
                                          input logic [7:0] tgt);
    if (j)          return tgt;
    else if (b & z) return tgt;
    else            return 8'((int'(cur) + 1) % 256);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; run = 1'b0; halt_req = 1'b0; jump = 1'b0; branch = 1'b0; acc_zero = 1'b0;
    target = 8'h00; rf_ren_wen = 1'b1; mem_ren_wen = 1'b1;
    tick; tick;
    reset = 1'b0;
    #1;
    checks++;
    if ({state, pc, retired, fetch_en, exec_en, rf_wen_g, mem_wen_g, halted} !==
        {3'd0, 8'h00, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got st=%0d pc=%h ret=%0d f=%b e=%b rf=%b mem=%b h=%b, want st=0 pc=00 ret=0 f=0 e=0 rf=0 mem=0 h=1",
               state, pc, retired, fetch_en, exec_en, rf_wen_g, mem_wen_g, halted);
    end
    checks++;
    if (pc_fe !== 8'hFE) begin
      errors++;
      $display("FAIL reset_pc_fe: got %h want fe", pc_fe);
    end
    tick;
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL idle_hold: got state %0d want 0", state);
    end
    model_pc = 8'h00; model_pc_fe = 8'hFE; model_retired = 16'd0;
  endtask

  // Pulses run from IDLE or HALTED; halt_req is held high alongside to show run wins.
  task automatic start_run(input logic with_halt);
    run = 1'b1; halt_req = with_halt;
    tick;
    run = 1'b0; halt_req = 1'b0;
    checks++;
    if ({state, pc, pc_fe, fetch_en, halted} !== {3'd1, model_pc, model_pc_fe, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL start_run: got st=%0d pc=%h pc_fe=%h f=%b h=%b, want st=1 pc=%h pc_fe=%h f=1 h=0",
               state, pc, pc_fe, fetch_en, halted, model_pc, model_pc_fe);
    end
  endtask

  // One full instruction starting in FETCH; control inputs are random except during EXECUTE.
  task automatic do_instr(input logic j, b, z, input logic [7:0] tgt, input int halt_phase);
    logic [7:0] exp_next, exp_next_fe;
    logic       rf, mem, stop;
    logic [2:0] exp_st;
    stop        = 1'b0;
    exp_next    = ref_next(model_pc, j, b, z, tgt);
    exp_next_fe = ref_next(model_pc_fe, j, b, z, tgt);
    for (int p = 0; p < 4; p++) begin
      rf  = 1'($urandom_range(0, 1));
      mem = 1'($urandom_range(0, 1));
      rf_ren_wen = rf; mem_ren_wen = mem;
      halt_req = (p == halt_phase);
      if (halt_req) stop = 1'b1;
      if (p == 2) begin
        jump = j; branch = b; acc_zero = z; target = tgt;
      end else begin
        jump = 1'($urandom_range(0, 1)); branch = 1'($urandom_range(0, 1));
        acc_zero = 1'($urandom_range(0, 1)); target = 8'($urandom);
      end
      #1;
      exp_st = 3'(p + 1);
      checks++;
      if ({state, pc, pc_fe, fetch_en, exec_en, rf_wen_g, mem_wen_g, halted} !==
          {exp_st, model_pc, model_pc_fe, p == 0, p == 2, rf && p == 3, mem && p == 3, 1'b0}) begin
        errors++;
        $display("FAIL phase%0d: got st=%0d pc=%h pc_fe=%h f=%b e=%b rf=%b mem=%b h=%b, want st=%0d pc=%h pc_fe=%h f=%b e=%b rf=%b mem=%b h=0",
                 p, state, pc, pc_fe, fetch_en, exec_en, rf_wen_g, mem_wen_g, halted,
                 exp_st, model_pc, model_pc_fe, p == 0, p == 2, rf && p == 3, mem && p == 3);
      end
      tick;
    end
    halt_req = 1'b0; rf_ren_wen = 1'b0; mem_ren_wen = 1'b0;
    model_pc = exp_next; model_pc_fe = exp_next_fe; model_retired = model_retired + 16'd1;
    exp_st = stop ? 3'd5 : 3'd1;
    #1;
    checks++;
    if ({state, pc, pc_fe, retired, halted, rf_wen_g} !==
        {exp_st, model_pc, model_pc_fe, model_retired, stop, 1'b0}) begin
      errors++;
      $display("FAIL retire: got st=%0d pc=%h pc_fe=%h ret=%0d h=%b rf=%b, want st=%0d pc=%h pc_fe=%h ret=%0d h=%b rf=0",
               state, pc, pc_fe, retired, halted, rf_wen_g, exp_st, model_pc, model_pc_fe,
               model_retired, stop);
    end
  endtask

  task automatic test_sequential;
    start_run(1'b0);
    for (int i = 0; i < 3; i++) do_instr(1'b0, 1'b0, 1'b0, 8'h00, -1);
  endtask

  task automatic test_halt;
    do_instr(1'b0, 1'b0, 1'b0, 8'h00, 1);
    halt_req = 1'b1;
    for (int i = 0; i < 3; i++) tick;
    halt_req = 1'b0;
    checks++;
    if ({state, pc, halted} !== {3'd5, 8'h04, 1'b1}) begin
      errors++;
      $display("FAIL halted_hold: got st=%0d pc=%h h=%b want st=5 pc=04 h=1", state, pc, halted);
    end
    start_run(1'b1);
    do_instr(1'b0, 1'b0, 1'b0, 8'h00, -1);
    do_instr(1'b0, 1'b0, 1'b0, 8'h00, 3);
    start_run(1'b0);
  endtask

  task automatic test_jump;
    do_instr(1'b1, 1'b0, 1'b0, 8'h20, -1);
    do_instr(1'b1, 1'b1, 1'b1, 8'h40, -1);
    do_instr(1'b1, 1'b0, 1'b0, 8'h40, -1);
  endtask

  task automatic test_branch;
    do_instr(1'b1, 1'b0, 1'b0, 8'h10, -1);
    do_instr(1'b0, 1'b1, 1'b1, 8'h08, -1);
    do_instr(1'b1, 1'b0, 1'b0, 8'h10, -1);
    do_instr(1'b0, 1'b1, 1'b0, 8'h08, -1);
    do_instr(1'b1, 1'b0, 1'b0, 8'hFF, -1);
    do_instr(1'b0, 1'b0, 1'b0, 8'h00, -1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      int hp;
      hp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               8'($urandom), hp);
      if (hp >= 0) start_run(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_instr;
    for (int p = 0; p < 2; p++) tick;
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset_exec: got state %0d want 3", state);
    end
    reset = 1'b1; mem_ren_wen = 1'b1; rf_ren_wen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({mem_wen_g, rf_wen_g} !== 2'b00) begin
        errors++;
        $display("FAIL reset_gate%0d: got mem=%b rf=%b want 0 0", i, mem_wen_g, rf_wen_g);
      end
      tick;
      reset = 1'b0;
    end
    checks++;
    if ({state, pc, pc_fe, retired, halted, mem_wen_g} !==
        {3'd0, 8'h00, 8'hFE, 16'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got st=%0d pc=%h pc_fe=%h ret=%0d h=%b mem=%b, want st=0 pc=00 pc_fe=fe ret=0 h=1 mem=0",
               state, pc, pc_fe, retired, halted, mem_wen_g);
    end
    mem_ren_wen = 1'b0; rf_ren_wen = 1'b0;
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_halt;
    test_jump;
    test_branch;
    test_random;
    test_reset_mid_instr;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
